// File: rtl/quad_pkg.sv
// quad_pkg: shared definitions for the multi-channel quadrature decoder.
//   - default parameter constants
//   - step_t classification of a filtered {A,B} transition
//   - forward/reverse transition codes, 4-bit {prev_a, prev_b, cur_a, cur_b}
//   - decode_step(): transition code -> step_t
//   - sat_signed(): clamp a 64-bit signed value to a narrower signed range
package quad_pkg;

  localparam int DEF_NUM_CHANNELS  = 4;
  localparam int DEF_COUNT_WIDTH   = 32;
  localparam int DEF_FILTER_DEPTH  = 4;
  localparam int DEF_SAMPLE_PERIOD = 100000;
  localparam int DEF_VEL_WIDTH     = 16;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // Forward cycle 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [3:0] FWD_00_10 = 4'b0010;
  localparam logic [3:0] FWD_10_11 = 4'b1011;
  localparam logic [3:0] FWD_11_01 = 4'b1101;
  localparam logic [3:0] FWD_01_00 = 4'b0100;
  // Reverse cycle 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [3:0] REV_00_01 = 4'b0001;
  localparam logic [3:0] REV_01_11 = 4'b0111;
  localparam logic [3:0] REV_11_10 = 4'b1110;
  localparam logic [3:0] REV_10_00 = 4'b1000;

  function automatic step_t decode_step(input logic [3:0] code);
    case (code)
      FWD_00_10, FWD_10_11, FWD_11_01, FWD_01_00: return STEP_FWD;
      REV_00_01, REV_01_11, REV_11_10, REV_10_00: return STEP_REV;
      // Both bits flipped at once: the direction cannot be known.
      default: return ((code[3:2] ^ code[1:0]) == 2'b11) ? STEP_ILLEGAL : STEP_NONE;
    endcase
  endfunction

  // Clamp v to [-(2^(w-1)), 2^(w-1)-1]; w must be in 2..63.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// quad_channel: one encoder channel.
//   2-flop synchroniser and stability filter on each input, x4 decode with a
//   registered step, wrap-around position counter and sticky error flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   quad_a, quad_b      raw encoder inputs (asynchronous)
//   count_clear         synchronous position clear (wins over a step)
//   error_clear         clears the sticky error (a coincident set wins)
//   count               position, two's complement, wraps
//   error               sticky illegal-transition flag
//   pos_zero            high in any cycle where the position is being zeroed
// Optional (macro QUAD_INDEX_EN): quad_i index input, index_arm, index_seen.
module quad_channel
  import quad_pkg::*;
#(
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int FILTER_DEPTH = DEF_FILTER_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   quad_a,
  input  logic                   quad_b,
`ifdef QUAD_INDEX_EN
  input  logic                   quad_i,
  input  logic                   index_arm,
  output logic                   index_seen,
`endif
  input  logic                   count_clear,
  input  logic                   error_clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   error,
  output logic                   pos_zero
);

`ifdef QUAD_INDEX_EN
  localparam int NI = 3;
`else
  localparam int NI = 2;
`endif
  localparam int FW = $clog2(FILTER_DEPTH + 1);

  logic [NI-1:0] raw;
  logic [NI-1:0] sync1_reg;
  logic [NI-1:0] sync2_reg;
  logic [NI-1:0] filt;

`ifdef QUAD_INDEX_EN
  assign raw = {quad_i, quad_a, quad_b};
`else
  assign raw = {quad_a, quad_b};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // The filtered bit follows only after FILTER_DEPTH consecutive cycles of
  // disagreement; any agreeing cycle restarts the count.
  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_filt
      logic [FW-1:0] stab_cnt_reg;
      logic          filt_bit_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          stab_cnt_reg <= '0;
          filt_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] == filt_bit_reg) begin
          stab_cnt_reg <= '0;
        end else if (stab_cnt_reg == FW'(FILTER_DEPTH - 1)) begin
          filt_bit_reg <= sync2_reg[gi];
          stab_cnt_reg <= '0;
        end else begin
          stab_cnt_reg <= stab_cnt_reg + 1'b1;
        end
      end
      assign filt[gi] = filt_bit_reg;
    end
  endgenerate

  logic [1:0]             prev_ab_reg;
  step_t                  step_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   error_reg;

  // Transition is classified into step_reg one cycle before it is applied,
  // keeping the decode out of the counter's carry path.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab_reg <= 2'b00;
      step_reg    <= STEP_NONE;
    end else begin
      prev_ab_reg <= filt[1:0];
      step_reg    <= decode_step({prev_ab_reg, filt[1:0]});
    end
  end

`ifdef QUAD_INDEX_EN
  logic prev_i_reg;
  logic index_seen_reg;
  logic index_hit;
  assign index_hit = filt[2] & ~prev_i_reg & index_arm;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_i_reg     <= 1'b0;
      index_seen_reg <= 1'b0;
    end else begin
      prev_i_reg <= filt[2];
      if (index_hit)        index_seen_reg <= 1'b1;
      else if (error_clear) index_seen_reg <= 1'b0;
    end
  end
  assign index_seen = index_seen_reg;
  assign pos_zero   = count_clear | index_hit;
`else
  assign pos_zero = count_clear;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (pos_zero) begin
      count_reg <= '0;
    end else if (step_reg == STEP_FWD) begin
      count_reg <= count_reg + 1'b1;
    end else if (step_reg == STEP_REV) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if (step_reg == STEP_ILLEGAL) begin
      error_reg <= 1'b1;
    end else if (error_clear) begin
      error_reg <= 1'b0;
    end
  end

  assign count = count_reg;
  assign error = error_reg;

endmodule

// File: rtl/quad_decoder_mc.sv
// quad_decoder_mc: multi-channel quadrature decoder with shared velocity timer.
//   NUM_CHANNELS quad_channel instances, a free-running period counter and
//   per-channel snapshot/saturation producing steps-per-period velocity.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   quadA, quadB                raw encoder inputs, one bit per channel
//   count_clear, error_clear    per-channel position / error clears
//   count                       positions, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   velocity                    signed steps per period, channel i at [i*VEL_WIDTH +: VEL_WIDTH]
//   velocity_valid              one-cycle pulse when velocity updates
//   error                       sticky illegal-transition flags
// Optional (macro QUAD_INDEX_EN): quadI, index_arm inputs, index_seen output.
module quad_decoder_mc
  import quad_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int FILTER_DEPTH  = DEF_FILTER_DEPTH,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int VEL_WIDTH     = DEF_VEL_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CHANNELS-1:0]             quadA,
  input  logic [NUM_CHANNELS-1:0]             quadB,
`ifdef QUAD_INDEX_EN
  input  logic [NUM_CHANNELS-1:0]             quadI,
  input  logic [NUM_CHANNELS-1:0]             index_arm,
  output logic [NUM_CHANNELS-1:0]             index_seen,
`endif
  input  logic [NUM_CHANNELS-1:0]             count_clear,
  input  logic [NUM_CHANNELS-1:0]             error_clear,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] count,
  output logic [NUM_CHANNELS*VEL_WIDTH-1:0]   velocity,
  output logic                                velocity_valid,
  output logic [NUM_CHANNELS-1:0]             error
);

  localparam int PW = $clog2(SAMPLE_PERIOD);

  logic [PW-1:0] period_reg;
  logic          tick;
  logic          velocity_valid_reg;

  assign tick = (period_reg == PW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      period_reg         <= '0;
      velocity_valid_reg <= 1'b0;
    end else begin
      period_reg         <= tick ? '0 : period_reg + 1'b1;
      velocity_valid_reg <= tick;
    end
  end

  assign velocity_valid = velocity_valid_reg;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [COUNT_WIDTH-1:0]        ch_count;
      logic                          ch_zero;
      logic [COUNT_WIDTH-1:0]        snap_reg;
      logic signed [COUNT_WIDTH-1:0] delta;
      logic signed [VEL_WIDTH-1:0]   vel_sat;
      logic [VEL_WIDTH-1:0]          vel_reg;

      quad_channel #(
        .COUNT_WIDTH  (COUNT_WIDTH),
        .FILTER_DEPTH (FILTER_DEPTH)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .quad_a      (quadA[gi]),
        .quad_b      (quadB[gi]),
`ifdef QUAD_INDEX_EN
        .quad_i      (quadI[gi]),
        .index_arm   (index_arm[gi]),
        .index_seen  (index_seen[gi]),
`endif
        .count_clear (count_clear[gi]),
        .error_clear (error_clear[gi]),
        .count       (ch_count),
        .error       (error[gi]),
        .pos_zero    (ch_zero)
      );

      // Wrapping subtraction gives the true step count as long as fewer than
      // 2^(COUNT_WIDTH-1) steps happen within one period.
      assign delta   = ch_count - snap_reg;
      assign vel_sat = VEL_WIDTH'(sat_signed(64'(delta), VEL_WIDTH));

      // The snapshot takes the pre-step count, so a step landing on the tick
      // belongs to the following period. A zeroed position restarts at 0.
      always_ff @(posedge clk) begin
        if (reset) begin
          snap_reg <= '0;
          vel_reg  <= '0;
        end else begin
          if (ch_zero)   snap_reg <= '0;
          else if (tick) snap_reg <= ch_count;
          if (tick)      vel_reg  <= vel_sat;
        end
      end

      assign count[gi*COUNT_WIDTH +: COUNT_WIDTH] = ch_count;
      assign velocity[gi*VEL_WIDTH +: VEL_WIDTH]  = vel_reg;
    end
  endgenerate

endmodule

// File: tb/tb_quad_decoder_mc.sv
// Directed testbench for quad_decoder_mc (2 channels, FILTER_DEPTH 4,
// SAMPLE_PERIOD 1000, VEL_WIDTH 8 so saturation is reachable quickly).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_quad_decoder_mc;

  localparam int NC = 2;
  localparam int CW = 32;
  localparam int FD = 4;
  localparam int SP = 1000;
  localparam int VW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    quadA, quadB, count_clear, error_clear;
  logic [NC*CW-1:0] count;
  logic [NC*VW-1:0] velocity;
  logic             velocity_valid;
  logic [NC-1:0]    error;
`ifdef QUAD_INDEX_EN
  logic [NC-1:0]    quadI, index_arm, index_seen;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int phase [NC];

  always #5 clk = ~clk;

  quad_decoder_mc #(
    .NUM_CHANNELS  (NC),
    .COUNT_WIDTH   (CW),
    .FILTER_DEPTH  (FD),
    .SAMPLE_PERIOD (SP),
    .VEL_WIDTH     (VW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .quadA          (quadA),
    .quadB          (quadB),
`ifdef QUAD_INDEX_EN
    .quadI          (quadI),
    .index_arm      (index_arm),
    .index_seen     (index_seen),
`endif
    .count_clear    (count_clear),
    .error_clear    (error_clear),
    .count          (count),
    .velocity       (velocity),
    .velocity_valid (velocity_valid),
    .error          (error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-16s got %0h exp %0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cnt(input int ch);
    return 64'(count[ch*CW +: CW]);
  endfunction

  function automatic logic [63:0] vel(input int ch);
    return 64'(velocity[ch*VW +: VW]);
  endfunction

  // Phase 0..3 maps to {A,B} = 00,10,11,01 (forward order).
  task automatic drive_phase(input int ch);
    quadA[ch] = (phase[ch] == 1) || (phase[ch] == 2);
    quadB[ch] = (phase[ch] == 2) || (phase[ch] == 3);
  endtask

  task automatic step(input int ch, input int dir);
    phase[ch] = (phase[ch] + dir + 4) % 4;
    drive_phase(ch);
    repeat (5) @(negedge clk);
  endtask

  task automatic steps(input int ch, input int dir, input int n);
    for (int k = 0; k < n; k++) step(ch, dir);
  endtask

  // Returns on the first falling edge where velocity_valid is high.
  task automatic wait_valid(input string tag);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!velocity_valid && waited < 2*SP + 10);
    if (!velocity_valid) check({tag, "_timeout"}, 64'(waited), 64'(SP));
  endtask

  initial begin
    reset = 1'b1;
    quadA = '0; quadB = '0; count_clear = '0; error_clear = '0;
`ifdef QUAD_INDEX_EN
    quadI = '0; index_arm = '0;
`endif
    for (int c = 0; c < NC; c++) phase[c] = 0;
    repeat (3) @(negedge clk);
    check("rst_count0", cnt(0), 64'd0);
    check("rst_count1", cnt(1), 64'd0);
    check("rst_vel", 64'(velocity), 64'd0);
    check("rst_valid", 64'(velocity_valid), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 3-cycle glitch on A must be rejected.
    quadA[0] = 1'b1;
    repeat (3) @(negedge clk);
    quadA[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_rej", cnt(0), 64'd0);

    // Held level: count moves on the 7th edge after the first sampling edge.
    phase[0] = 1;
    drive_phase(0);
    repeat (7) @(negedge clk);
    check("lat_before", cnt(0), 64'd0);
    @(negedge clk);
    check("lat_at", cnt(0), 64'd1);

    steps(0, 1, 7);
    repeat (8) @(negedge clk);
    check("fwd8", cnt(0), 64'd8);
    steps(0, -1, 8);
    repeat (8) @(negedge clk);
    check("rev8", cnt(0), 64'd0);
    steps(0, -1, 1);
    repeat (8) @(negedge clk);
    check("wrap_neg", cnt(0), 64'hFFFF_FFFF);
    count_clear[0] = 1'b1;
    @(negedge clk);
    count_clear[0] = 1'b0;
    check("clear", cnt(0), 64'd0);

    // Clear on the same edge a step would land: step is lost, not deferred.
    steps(0, 1, 3);
    repeat (8) @(negedge clk);
    check("pre_clr_step", cnt(0), 64'd3);
    phase[0] = (phase[0] + 1) % 4;
    drive_phase(0);
    repeat (7) @(negedge clk);
    count_clear[0] = 1'b1;
    @(negedge clk);
    count_clear[0] = 1'b0;
    check("clr_vs_step", cnt(0), 64'd0);
    repeat (10) @(negedge clk);
    check("clr_discard", cnt(0), 64'd0);

    // Illegal 00 -> 11 on channel 1.
    quadA[1] = 1'b1;
    quadB[1] = 1'b1;
    phase[1] = 2;
    repeat (12) @(negedge clk);
    check("illegal_cnt", cnt(1), 64'd0);
    check("illegal_err1", 64'(error[1]), 64'd1);
    check("illegal_err0", 64'(error[0]), 64'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(error[1]), 64'd1);
    error_clear[1] = 1'b1;
    @(negedge clk);
    error_clear[1] = 1'b0;
    check("err_clear", 64'(error[1]), 64'd0);
    steps(1, 1, 1);
    repeat (8) @(negedge clk);
    check("post_illegal", cnt(1), 64'd1);

    // Velocity: 50 steps in one period, then an idle period.
    wait_valid("sync0");
    steps(0, 1, 50);
    wait_valid("vel50");
    check("vel50", vel(0), 64'd50);
    check("vel_ch1_idle", vel(1), 64'd0);
    @(negedge clk);
    check("valid_pulse", 64'(velocity_valid), 64'd0);
    wait_valid("vel_idle");
    check("vel_idle", vel(0), 64'd0);
    steps(0, 1, 150);
    wait_valid("sat_pos");
    check("sat_pos", vel(0), 64'h7F);
    steps(0, -1, 150);
    wait_valid("sat_neg");
    check("sat_neg", vel(0), 64'h80);

    // Clear coincident with the tick: velocity from pre-clear count.
    steps(0, 1, 10);
    repeat (SP - 1 - 50) @(negedge clk);
    count_clear[0] = 1'b1;
    @(negedge clk);
    count_clear[0] = 1'b0;
    check("tick_clr_valid", 64'(velocity_valid), 64'd1);
    check("tick_clr_vel", vel(0), 64'd10);
    check("tick_clr_cnt", cnt(0), 64'd0);
    steps(0, 1, 3);
    wait_valid("after_clr");
    check("after_clr_vel", vel(0), 64'd3);
    check("after_clr_cnt", cnt(0), 64'd3);

    // Reset in the middle of a step stream, with a filter change in flight.
    steps(0, 1, 2);
    phase[0] = (phase[0] + 1) % 4;
    drive_phase(0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    phase[0] = 0; phase[1] = 0;
    drive_phase(0); drive_phase(1);
    @(negedge clk);
    check("mid_rst_cnt0", cnt(0), 64'd0);
    check("mid_rst_cnt1", cnt(1), 64'd0);
    check("mid_rst_vel", 64'(velocity), 64'd0);
    check("mid_rst_err", 64'(error), 64'd0);
    check("mid_rst_valid", 64'(velocity_valid), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    steps(0, 1, 4);
    repeat (8) @(negedge clk);
    check("resume_cnt0", cnt(0), 64'd4);
    check("resume_cnt1", cnt(1), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
